// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared widths, arbiter state encoding and bus-direction constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int BANK_W      = 2;
  localparam int HOST_ADDR_W = 11;

  localparam logic HOST_TO_FPGA = 1'b1;
  localparam logic FPGA_TO_HOST = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_HOLD  = 3'd4,
    RELEASE  = 3'd5
  } arbState_t;

endpackage

`default_nettype wire

// File: rtl/strobe_sync.sv
// ============================================================================
// Module   : strobe_sync
// Purpose  : Multi-stage synchroniser for an active-low async strobe, plus a
//            one-cycle pulse on its synchronised falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobeN,
  output logic syncN,
  output logic fallPulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Idle level of the strobe is high, so reset to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], strobeN};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign syncN     = r_sync[SYNC_STAGES-1];
  assign fallPulse = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/vram_host_arbiter.sv
// ============================================================================
// Module   : vram_host_arbiter
// Purpose  : Sequences host writes, host reads and bank register accesses onto
//            the VRAM ports; display readout has absolute priority on reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_host_arbiter #(
  parameter int ADDR_W      = vga_pkg::VRAM_ADDR_W,
  parameter int BANK_W      = vga_pkg::BANK_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [vga_pkg::HOST_ADDR_W-1:0]  hostBusAddr,
  input  logic [7:0]                       hostBusDataIn,
  output logic [7:0]                       hostBusDataOut,
  output logic                             hostBusDataOe,
  input  logic                             nHostRMEM,
  input  logic                             nHostWMEM,
  input  logic                             nHostVRAMEn,
  input  logic                             nHostBankRegEn,
  output logic                             hostBusDir,
  input  logic                             dispReq,
  input  logic [ADDR_W-1:0]                dispAddr,
  output logic [ADDR_W-1:0]                vramRdAddr,
  input  logic [7:0]                       vramRdData,
  output logic [ADDR_W-1:0]                vramWrAddr,
  output logic [7:0]                       vramWrData,
  output logic                             vramWr,
  output logic [BANK_W-1:0]                bank
);

  import vga_pkg::*;

  localparam int BANK_PAD = 8 - BANK_W;

  arbState_t r_state;
  arbState_t w_stateNext;

  logic              w_rdSync, w_rdStart;
  logic              w_wrSync, w_wrStart;
  logic              w_vramSel, w_bankSel;
  logic [ADDR_W-1:0] w_hostAddr;

  logic w_doWr, w_doBankWr, w_doRdLatch, w_doBankRd, w_doCapture;

  logic [BANK_W-1:0] r_bank;
  logic [ADDR_W-1:0] r_hostRdAddr;
  logic [ADDR_W-1:0] r_vramWrAddr;
  logic [7:0]        r_vramWrData;
  logic              r_vramWr;
  logic [7:0]        r_hostDataOut;

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rdSync (
    .clk       (clk),
    .rst       (rst),
    .strobeN   (nHostRMEM),
    .syncN     (w_rdSync),
    .fallPulse (w_rdStart)
  );

  strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wrSync (
    .clk       (clk),
    .rst       (rst),
    .strobeN   (nHostWMEM),
    .syncN     (w_wrSync),
    .fallPulse (w_wrStart)
  );

  assign w_vramSel  = ~nHostVRAMEn;
  assign w_bankSel  = ~nHostBankRegEn;
  assign w_hostAddr = {r_bank, hostBusAddr};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext   = r_state;
    w_doWr        = 1'b0;
    w_doBankWr    = 1'b0;
    w_doRdLatch   = 1'b0;
    w_doBankRd    = 1'b0;
    w_doCapture   = 1'b0;
    hostBusDataOe = 1'b0;
    hostBusDir    = HOST_TO_FPGA;
    case (r_state)
      IDLE: begin
        // A read start takes precedence; a simultaneous write start is dropped.
        if (w_rdStart) begin
          if (w_bankSel) begin
            w_doBankRd  = 1'b1;
            w_stateNext = RD_HOLD;
          end else if (w_vramSel) begin
            w_doRdLatch = 1'b1;
            w_stateNext = RD_WAIT;
          end
        end else if (w_wrStart) begin
          if (w_bankSel) begin
            w_doBankWr  = 1'b1;
            w_stateNext = RELEASE;
          end else if (w_vramSel) begin
            w_doWr      = 1'b1;
            w_stateNext = WR;
          end
        end
      end
      WR:       w_stateNext = RELEASE;
      RD_WAIT:  if (!dispReq) w_stateNext = RD_ISSUE;
      RD_ISSUE: begin
        w_doCapture = 1'b1;
        w_stateNext = RD_HOLD;
      end
      RD_HOLD: begin
        if (w_rdSync) begin
          w_stateNext = IDLE;
        end else begin
          hostBusDataOe = 1'b1;
          hostBusDir    = FPGA_TO_HOST;
        end
      end
      RELEASE:  if (w_wrSync) w_stateNext = IDLE;
      default:  w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank        <= '0;
      r_hostRdAddr  <= '0;
      r_vramWrAddr  <= '0;
      r_vramWrData  <= '0;
      r_vramWr      <= 1'b0;
      r_hostDataOut <= '0;
    end else begin
      r_vramWr <= w_doWr;
      if (w_doWr) begin
        r_vramWrAddr <= w_hostAddr;
        r_vramWrData <= hostBusDataIn;
      end
      if (w_doBankWr)  r_bank        <= hostBusDataIn[BANK_W-1:0];
      if (w_doRdLatch) r_hostRdAddr  <= w_hostAddr;
      if (w_doBankRd)  r_hostDataOut <= {{BANK_PAD{1'b0}}, r_bank};
      if (w_doCapture) r_hostDataOut <= vramRdData;
    end
  end

  // Display readout is never stalled: it owns the read port whenever it asks.
  assign vramRdAddr     = dispReq ? dispAddr : r_hostRdAddr;
  assign vramWrAddr     = r_vramWrAddr;
  assign vramWrData     = r_vramWrData;
  assign vramWr         = r_vramWr;
  assign bank           = r_bank;
  assign hostBusDataOut = r_hostDataOut;

endmodule

`default_nettype wire

// File: doc/vram_host_arbiter.md
Name: vram_host_arbiter

Overview:
- Sequences all host-bus accesses to the text-mode VRAM: host writes, host reads and the bank register.
- The VRAM read port is shared with display readout. Display always owns it when it requests it; host reads are slotted into idle cycles.
- Synchronises the asynchronous host strobes and drives host-bus data/direction during reads.
- Sits between the host bus pins, the vram block and the readout block.

Parameters:
- ADDR_W, 13, VRAM address width; equals BANK_W plus 11.
- BANK_W, 2, bank register width; the bank supplies the upper VRAM address bits.
- SYNC_STAGES, 2, flip-flop stages on each host strobe synchroniser (minimum 2).

Ports:
- clk  in  1  VGA dot clock.
- rst  in  1  synchronous, active-high reset.
- hostBusAddr  in  11  host address within the bank.
- hostBusDataIn  in  8  host write data.
- hostBusDataOut  out  8  read data to host.
- hostBusDataOe  out  1  1 = FPGA drives hostBusData.
- nHostRMEM  in  1  host read strobe, active-low, asynchronous.
- nHostWMEM  in  1  host write strobe, active-low, asynchronous.
- nHostVRAMEn  in  1  VRAM window select, active-low.
- nHostBankRegEn  in  1  bank register select, active-low.
- hostBusDir  out  1  transceiver direction: 1 = host→FPGA, 0 = FPGA→host.
- dispReq  in  1  readout needs the read port this cycle.
- dispAddr  in  ADDR_W  readout address.
- vramRdAddr  out  ADDR_W  VRAM read address.
- vramRdData  in  8  VRAM read data; valid 1 cycle after the address.
- vramWrAddr  out  ADDR_W  VRAM write address.
- vramWrData  out  8  VRAM write data.
- vramWr  out  1  one-cycle write enable.
- bank  out  BANK_W  current bank register value.

Behaviour:
- Reset values: state=IDLE, bank=0, vramWr=0, vramWrAddr=0, vramWrData=0, hostBusDataOut=0, hostBusDataOe=0, hostBusDir=1.
- Strobe synchronisation:
  - nHostRMEM and nHostWMEM each pass through SYNC_STAGES flip-flops.
  - A 1→0 transition on the synchronised signal yields a one-cycle start pulse.
  - Address, data and selects are sampled on that start cycle; the host holds them stable throughout the strobe.
- Select decode: both selects low → bank register wins; neither low → transaction ignored, FSM stays IDLE.
- Read-port mux: vramRdAddr = dispAddr whenever dispReq=1, otherwise the host read address register. Display is never stalled.
- FSM states: IDLE, WR, RD_WAIT, RD_ISSUE, RD_HOLD, RELEASE.
  - IDLE: write start with VRAM selected → WR. Write start with bank selected → bank ← hostBusDataIn[BANK_W-1:0], go to RELEASE. Read start with VRAM selected → RD_WAIT, latch address {bank, hostBusAddr}. Read start with bank selected → hostBusDataOut ← zero-extended bank, go to RD_HOLD.
  - WR: vramWr=1 for exactly one cycle; vramWrAddr = {bank, hostBusAddr}; vramWrData = hostBusDataIn latched at the start pulse. Next state RELEASE. Write latency from start pulse is 1 cycle.
  - RD_WAIT: if dispReq=0, present the host address and go to RD_ISSUE; otherwise stay.
  - RD_ISSUE: capture vramRdData into hostBusDataOut; go to RD_HOLD. Capture occurs 1 cycle after issue, regardless of dispReq in this cycle.
  - RD_HOLD: hostBusDir=0 and hostBusDataOe=1 while synchronised nHostRMEM=0. When it rises: hostBusDir=1, hostBusDataOe=0 in the same cycle, go to IDLE.
  - RELEASE: wait for synchronised nHostWMEM=1, then go to IDLE. This makes every strobe exactly one transaction.
- Start pulses arriving in any non-IDLE state are dropped.
- Read and write starting in the same cycle: the read is served and the write dropped; this is a host protocol violation.
- The write port is independent, so WR never waits on dispReq.
- rst asserted mid-transaction: next cycle all outputs take their reset values, bus released, in-flight access abandoned, bank cleared.
- Read-after-write to the same address returns the new data (the write completes before the next start).

Decomposition:
- Package vga_pkg:
  - VRAM_ADDR_W=13, BANK_W=2, HOST_ADDR_W=11.
  - Arbiter state enum.
  - HOST_TO_FPGA=1 / FPGA_TO_HOST=0 direction constants.
- Sub-module strobe_sync: SYNC_STAGES flip-flop synchroniser plus falling-edge pulse. Instantiated once for nHostRMEM and once for nHostWMEM.

Test Plan:
- Write A: bank=1, hostBusAddr=0x005, data 0xA5, nHostWMEM low with nHostVRAMEn low → exactly one vramWr pulse, vramWrAddr=0x0805, vramWrData=0xA5, SYNC_STAGES+1 cycles after the strobe falls.
- Read A: read during dispReq=0, VRAM returns 0x3C → hostBusDataOut=0x3C, hostBusDir=0, hostBusDataOe=1 until the strobe rises; hostBusDir=1 on the first cycle after the synchronised strobe goes high.
- Read B: read while dispReq is held high for 40 cycles → vramRdAddr tracks dispAddr for all 40 cycles; host address is presented on cycle 41; data is correct.
- Bank register: write 0x03 with nHostBankRegEn low → bank=3. Read it back → 0x03. Subsequent VRAM write at hostBusAddr 0 → vramWrAddr=0x1800.
- Both selects low on a write of 0x02 → bank=2 and no vramWr pulse. Strobe held low for 20 cycles → only one transaction occurs.
- rst asserted during RD_HOLD → next cycle hostBusDataOe=0, hostBusDir=1, bank=0, state IDLE; no spurious vramWr.
